multicycle_control: RTL and testbench

Parametrised multi-cycle control unit for the RISC-V core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back over a single shared memory port. It uses a ready handshake, a wait-state watchdog and optional illegal-opcode trapping. It sits between the instruction register (opcode) and the multi-cycle datapath, and decodes the same opcode set as the single-cycle control unit: R, I-logic, LUI, S, load, B, JAL, JALR, AUIPC.

---
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/write-back over one shared memory port.
// Define CONTROL_TRAP_EN to trap unknown opcodes; otherwise they retire as NOPs.
module multicycle_control #(
    parameter int ALU_OP_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              OP_i,
    input  logic                    Mem_Ready_i,
    output logic                    Mem_Req_o,
    output logic                    Mem_Read_o,
    output logic                    Mem_Write_o,
    output logic                    I_or_D_o,
    output logic                    IR_Write_o,
    output logic                    PC_Write_o,
    output logic                    Reg_Write_o,
    output logic [1:0]              ALU_Src_A_o,
    output logic [1:0]              ALU_Src_B_o,
    output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
    output logic [1:0]              Mem_to_Reg_o,
    output logic                    Branch_o,
    output logic                    Jalr_o,
    output logic                    AUIPC_o,
    output logic [2:0]              State_o,
    output logic                    Timeout_o,
    output logic                    Trap_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LUI, C_S, C_LOAD, C_B, C_JAL, C_JALR, C_AUIPC, C_BAD
    } cls_t;

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam bit         WD_EN    = (TIMEOUT_CYCLES != 0);

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0110111: return C_LUI;
            7'b0100011: return C_S;
            7'b0000011: return C_LOAD;
            7'b1100011: return C_B;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0010111: return C_AUIPC;
            default:    return C_BAD;
        endcase
    endfunction

    state_t     state, state_next;
    cls_t       cls_q;
    logic [7:0] wd_cnt;
    logic       wd_expired;
    logic       mem_phase;
    logic [2:0] alu_code;

    assign mem_phase  = (state == S_FETCH) || (state == S_MEM);
    assign wd_expired = WD_EN && (wd_cnt == WD_LIMIT);
    assign State_o    = state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // The class is captured once in DECODE so later states ignore IR changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cls_q <= C_BAD;
        else if (state == S_DECODE) cls_q <= classify(OP_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= 8'd0;
        else if (state_next != state)
            wd_cnt <= 8'd0;
        else if (mem_phase && !Mem_Ready_i && wd_cnt != 8'hFF)
            wd_cnt <= wd_cnt + 8'd1;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                // Ready takes priority over a watchdog expiring in the same cycle.
                if (Mem_Ready_i)     state_next = S_DECODE;
                else if (wd_expired) state_next = S_HALT;
            end
            S_DECODE: begin
                if (classify(OP_i) != C_BAD) state_next = S_EXEC;
                else begin
`ifdef CONTROL_TRAP_EN
                    state_next = S_TRAP;
`else
                    state_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_B:         state_next = S_FETCH;
                    C_LOAD, C_S: state_next = S_MEM;
                    default:     state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (Mem_Ready_i)     state_next = (cls_q == C_S) ? S_FETCH : S_WB;
                else if (wd_expired) state_next = S_HALT;
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        Mem_Req_o    = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        I_or_D_o     = 1'b0;
        IR_Write_o   = 1'b0;
        PC_Write_o   = 1'b0;
        Reg_Write_o  = 1'b0;
        ALU_Src_A_o  = 2'b00;
        ALU_Src_B_o  = 2'b00;
        alu_code     = 3'd0;
        Mem_to_Reg_o = 2'b00;
        Branch_o     = 1'b0;
        Jalr_o       = 1'b0;
        AUIPC_o      = 1'b0;
        Timeout_o    = 1'b0;
        Trap_o       = 1'b0;
        case (state)
            S_FETCH: begin
                Mem_Req_o   = 1'b1;
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = 2'b01;
                alu_code    = 3'd3;
                IR_Write_o  = Mem_Ready_i;
                PC_Write_o  = Mem_Ready_i;
            end
            S_DECODE: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b10;
                alu_code    = 3'd3;
            end
            S_EXEC: begin
                ALU_Src_A_o = (cls_q == C_AUIPC) ? 2'b10 : 2'b01;
                ALU_Src_B_o = (cls_q == C_R || cls_q == C_B) ? 2'b00 : 2'b10;
                Branch_o    = (cls_q == C_B);
                case (cls_q)
                    C_R:     alu_code = 3'd0;
                    C_I:     alu_code = 3'd1;
                    C_LUI:   alu_code = 3'd2;
                    C_LOAD:  alu_code = 3'd4;
                    C_B:     alu_code = 3'd5;
                    C_JAL:   alu_code = 3'd6;
                    C_JALR:  alu_code = 3'd7;
                    default: alu_code = 3'd3;
                endcase
            end
            S_MEM: begin
                Mem_Req_o   = 1'b1;
                I_or_D_o    = 1'b1;
                Mem_Read_o  = (cls_q == C_LOAD);
                Mem_Write_o = (cls_q == C_S);
            end
            S_WB: begin
                Reg_Write_o = 1'b1;
                if (cls_q == C_LOAD)                          Mem_to_Reg_o = 2'b01;
                else if (cls_q == C_JAL || cls_q == C_JALR)   Mem_to_Reg_o = 2'b10;
                PC_Write_o  = (cls_q == C_JAL || cls_q == C_JALR);
                Jalr_o      = (cls_q == C_JALR);
                AUIPC_o     = (cls_q == C_AUIPC);
            end
            S_TRAP: begin
`ifdef CONTROL_TRAP_EN
                Trap_o = 1'b1;
`endif
            end
            S_HALT:  Timeout_o = 1'b1;
            default: ;
        endcase
    end

    assign ALU_Op_o = ALU_OP_WIDTH'(alu_code);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; compares the full output bundle every cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] OP_i = 7'h00;
    logic       Mem_Ready_i = 1'b0;
    logic       Mem_Req_o, Mem_Read_o, Mem_Write_o, I_or_D_o;
    logic       IR_Write_o, PC_Write_o, Reg_Write_o;
    logic [1:0] ALU_Src_A_o, ALU_Src_B_o, Mem_to_Reg_o;
    logic [2:0] ALU_Op_o, State_o;
    logic       Branch_o, Jalr_o, AUIPC_o, Timeout_o, Trap_o;

    int passed = 0;
    int total  = 0;

    // Output bundle: {state, bus{req,rd,wr,iord,irw,pcw,rw}, src_a, src_b, alu_op, m2r, flags{br,jr,au,to,tr}}
    typedef logic [23:0] outs_t;
    typedef struct {
        logic [6:0] op;
        logic       rdy;
        outs_t      ev;
    } vec_t;

    outs_t obs;
    assign obs = {State_o, Mem_Req_o, Mem_Read_o, Mem_Write_o, I_or_D_o, IR_Write_o, PC_Write_o,
                  Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Mem_to_Reg_o,
                  Branch_o, Jalr_o, AUIPC_o, Timeout_o, Trap_o};

    multicycle_control #(.ALU_OP_WIDTH(3), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .OP_i(OP_i), .Mem_Ready_i(Mem_Ready_i),
        .Mem_Req_o(Mem_Req_o), .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o),
        .I_or_D_o(I_or_D_o), .IR_Write_o(IR_Write_o), .PC_Write_o(PC_Write_o),
        .Reg_Write_o(Reg_Write_o), .ALU_Src_A_o(ALU_Src_A_o), .ALU_Src_B_o(ALU_Src_B_o),
        .ALU_Op_o(ALU_Op_o), .Mem_to_Reg_o(Mem_to_Reg_o), .Branch_o(Branch_o),
        .Jalr_o(Jalr_o), .AUIPC_o(AUIPC_o), .State_o(State_o),
        .Timeout_o(Timeout_o), .Trap_o(Trap_o)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(input logic [2:0] st, input logic [6:0] bus, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [2:0] aop, input logic [1:0] m2r,
                                 input logic [4:0] flags);
        return {st, bus, sa, sb, aop, m2r, flags};
    endfunction

    function automatic vec_t v(input logic [6:0] op, input logic rdy, input outs_t ev);
        vec_t r;
        r.op = op; r.rdy = rdy; r.ev = ev;
        return r;
    endfunction

    // Hand-written expectations for recurring states
    localparam outs_t E_IDLE    = 24'h0;
    localparam outs_t E_FETCH_R = {3'd1, 7'b1100110, 2'b00, 2'b01, 3'd3, 2'b00, 5'b00000};
    localparam outs_t E_FETCH_W = {3'd1, 7'b1100000, 2'b00, 2'b01, 3'd3, 2'b00, 5'b00000};
    localparam outs_t E_DECODE  = {3'd2, 7'b0000000, 2'b10, 2'b10, 3'd3, 2'b00, 5'b00000};

    // Leaves the bench 1 ns after a rising edge, with the DUT in IDLE and reset released.
    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (obs !== E_IDLE) $display("FAIL reset_async: got %h expected %h", obs, E_IDLE);
        else passed++;
        apply_reset();
        @(negedge clk);
        total++;
        if (obs !== E_IDLE) $display("FAIL reset_idle: got %h expected %h", obs, E_IDLE);
        else passed++;
        @(posedge clk); #1;
        Mem_Ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== E_FETCH_R) $display("FAIL reset_first_fetch: got %h expected %h", obs, E_FETCH_R);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        vec_t t[$];
        apply_reset();
        t.push_back(v(7'h33, 1'b1, E_IDLE));
        t.push_back(v(7'h33, 1'b1, E_FETCH_R));
        t.push_back(v(7'h33, 1'b1, E_DECODE));
        // OP_i changes after DECODE; EXEC/WB must still follow the latched R class
        t.push_back(v(7'h7F, 1'b1, mk(3'd3, 7'b0000000, 2'b01, 2'b00, 3'd0, 2'b00, 5'b00000)));
        t.push_back(v(7'h7F, 1'b1, mk(3'd5, 7'b0000001, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00000)));
        t.push_back(v(7'h7F, 1'b1, E_FETCH_R));
        foreach (t[i]) begin
            OP_i = t[i].op; Mem_Ready_i = t[i].rdy;
            @(negedge clk);
            total++;
            if (obs !== t[i].ev) $display("FAIL rtype[%0d]: got %h expected %h", i, obs, t[i].ev);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        vec_t t[$];
        apply_reset();
        t.push_back(v(7'h03, 1'b1, E_IDLE));
        t.push_back(v(7'h03, 1'b1, E_FETCH_R));
        t.push_back(v(7'h03, 1'b0, E_DECODE));
        t.push_back(v(7'h03, 1'b0, mk(3'd3, 7'b0000000, 2'b01, 2'b10, 3'd4, 2'b00, 5'b00000)));
        for (int k = 0; k < 3; k++)
            t.push_back(v(7'h03, 1'b0, mk(3'd4, 7'b1101000, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00000)));
        t.push_back(v(7'h03, 1'b1, mk(3'd4, 7'b1101000, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00000)));
        t.push_back(v(7'h03, 1'b1, mk(3'd5, 7'b0000001, 2'b00, 2'b00, 3'd0, 2'b01, 5'b00000)));
        t.push_back(v(7'h03, 1'b1, E_FETCH_R));
        foreach (t[i]) begin
            OP_i = t[i].op; Mem_Ready_i = t[i].rdy;
            @(negedge clk);
            total++;
            if (obs !== t[i].ev) $display("FAIL load_wait[%0d]: got %h expected %h", i, obs, t[i].ev);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // JALR then JAL back to back without an intervening reset
    task automatic test_back_to_back();
        vec_t t[$];
        apply_reset();
        t.push_back(v(7'h67, 1'b1, E_IDLE));
        t.push_back(v(7'h67, 1'b1, E_FETCH_R));
        t.push_back(v(7'h67, 1'b1, E_DECODE));
        t.push_back(v(7'h67, 1'b1, mk(3'd3, 7'b0000000, 2'b01, 2'b10, 3'd7, 2'b00, 5'b00000)));
        t.push_back(v(7'h67, 1'b1, mk(3'd5, 7'b0000011, 2'b00, 2'b00, 3'd0, 2'b10, 5'b01000)));
        t.push_back(v(7'h6F, 1'b1, E_FETCH_R));
        t.push_back(v(7'h6F, 1'b1, E_DECODE));
        t.push_back(v(7'h6F, 1'b1, mk(3'd3, 7'b0000000, 2'b01, 2'b10, 3'd6, 2'b00, 5'b00000)));
        t.push_back(v(7'h6F, 1'b1, mk(3'd5, 7'b0000011, 2'b00, 2'b00, 3'd0, 2'b10, 5'b00000)));
        t.push_back(v(7'h63, 1'b1, E_FETCH_R));
        t.push_back(v(7'h63, 1'b1, E_DECODE));
        t.push_back(v(7'h63, 1'b1, mk(3'd3, 7'b0000000, 2'b01, 2'b00, 3'd5, 2'b00, 5'b10000)));
        t.push_back(v(7'h17, 1'b1, E_FETCH_R));
        t.push_back(v(7'h17, 1'b1, E_DECODE));
        t.push_back(v(7'h17, 1'b1, mk(3'd3, 7'b0000000, 2'b10, 2'b10, 3'd3, 2'b00, 5'b00000)));
        t.push_back(v(7'h17, 1'b1, mk(3'd5, 7'b0000001, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00100)));
        t.push_back(v(7'h17, 1'b1, E_FETCH_R));
        foreach (t[i]) begin
            OP_i = t[i].op; Mem_Ready_i = t[i].rdy;
            @(negedge clk);
            total++;
            if (obs !== t[i].ev) $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, t[i].ev);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        vec_t t[$];
        apply_reset();
        t.push_back(v(7'h33, 1'b0, E_IDLE));
        for (int k = 0; k < 5; k++) t.push_back(v(7'h33, 1'b0, E_FETCH_W));
        // HALT ignores ready and holds Timeout_o
        for (int k = 0; k < 3; k++)
            t.push_back(v(7'h33, 1'b1, mk(3'd7, 7'b0000000, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00010)));
        foreach (t[i]) begin
            OP_i = t[i].op; Mem_Ready_i = t[i].rdy;
            @(negedge clk);
            total++;
            if (obs !== t[i].ev) $display("FAIL timeout[%0d]: got %h expected %h", i, obs, t[i].ev);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ready_wins();
        vec_t t[$];
        apply_reset();
        t.push_back(v(7'h33, 1'b0, E_IDLE));
        for (int k = 0; k < 4; k++) t.push_back(v(7'h33, 1'b0, E_FETCH_W));
        t.push_back(v(7'h33, 1'b1, E_FETCH_R));
        t.push_back(v(7'h33, 1'b0, E_DECODE));
        t.push_back(v(7'h33, 1'b0, mk(3'd3, 7'b0000000, 2'b01, 2'b00, 3'd0, 2'b00, 5'b00000)));
        foreach (t[i]) begin
            OP_i = t[i].op; Mem_Ready_i = t[i].rdy;
            @(negedge clk);
            total++;
            if (obs !== t[i].ev) $display("FAIL ready_wins[%0d]: got %h expected %h", i, obs, t[i].ev);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_opcode();
        vec_t t[$];
        apply_reset();
        t.push_back(v(7'h7F, 1'b1, E_IDLE));
        t.push_back(v(7'h7F, 1'b1, E_FETCH_R));
        t.push_back(v(7'h7F, 1'b1, E_DECODE));
`ifdef CONTROL_TRAP_EN
        t.push_back(v(7'h33, 1'b1, mk(3'd6, 7'b0000000, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00001)));
        t.push_back(v(7'h33, 1'b1, mk(3'd6, 7'b0000000, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00001)));
`else
        t.push_back(v(7'h33, 1'b1, E_FETCH_R));
        t.push_back(v(7'h33, 1'b1, E_DECODE));
`endif
        foreach (t[i]) begin
            OP_i = t[i].op; Mem_Ready_i = t[i].rdy;
            @(negedge clk);
            total++;
            if (obs !== t[i].ev) $display("FAIL illegal_op[%0d]: got %h expected %h", i, obs, t[i].ev);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_store();
        vec_t t[$];
        outs_t e_mem_st;
        e_mem_st = mk(3'd4, 7'b1011000, 2'b00, 2'b00, 3'd0, 2'b00, 5'b00000);
        apply_reset();
        t.push_back(v(7'h23, 1'b1, E_IDLE));
        t.push_back(v(7'h23, 1'b1, E_FETCH_R));
        t.push_back(v(7'h23, 1'b1, E_DECODE));
        t.push_back(v(7'h23, 1'b1, mk(3'd3, 7'b0000000, 2'b01, 2'b10, 3'd3, 2'b00, 5'b00000)));
        t.push_back(v(7'h23, 1'b0, e_mem_st));
        t.push_back(v(7'h23, 1'b0, e_mem_st));
        foreach (t[i]) begin
            OP_i = t[i].op; Mem_Ready_i = t[i].rdy;
            @(negedge clk);
            total++;
            if (obs !== t[i].ev) $display("FAIL store_mem[%0d]: got %h expected %h", i, obs, t[i].ev);
            else passed++;
            @(posedge clk); #1;
        end
        // Asynchronous reset between clock edges must clear outputs at once
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        total++;
        if (obs !== E_IDLE) $display("FAIL store_async_reset: got %h expected %h", obs, E_IDLE);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        Mem_Ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== E_IDLE) $display("FAIL store_post_reset_idle: got %h expected %h", obs, E_IDLE);
        else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (obs !== E_FETCH_R) $display("FAIL store_post_reset_fetch: got %h expected %h", obs, E_FETCH_R);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_back_to_back();
        test_timeout();
        test_ready_wins();
        test_illegal_opcode();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
